fetch_queue: RTL and testbench

// Parametrised instruction-fetch stage with prefetch buffering. Issues word-addressed

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 79 +++++++
 tb/tb_fetch_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and sizing helper for the fetch stage
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0;
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0;

  // Pointer width with one wrap bit so full and empty differ.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - circular {pc, instr} buffer with sync flush and occupancy count
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_pc,
  input  logic [WORD_WIDTH-1:0] push_ir,
  input  logic                  pop,
  output logic [PW-1:0]         count,
  output logic [WORD_WIDTH-1:0] head_pc,
  output logic [WORD_WIDTH-1:0] head_ir
);

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [2*WORD_WIDTH-1:0] mem [DEPTH];
  logic [2*WORD_WIDTH-1:0] head;
  logic                    empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[PW-2:0]] <= {push_pc, push_ir};
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[PW-2:0]];

  // Decode sees a NOP and zero PC whenever nothing is queued.
  assign head_pc = empty ? '0 : head[2*WORD_WIDTH-1:WORD_WIDTH];
  assign head_ir = empty ? WORD_WIDTH'(NOP_INSTR) : head[WORD_WIDTH-1:0];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch with credit-limited prefetch into a small queue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = WORD_WIDTH'(BOOT_ADDR_DEFAULT),
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump,
  input  logic [WORD_WIDTH-1:0] target,
  output logic                  ram_en_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [WORD_WIDTH-1:0] ram_rdata_b,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [WORD_WIDTH-1:0] pc_id,
  output logic [WORD_WIDTH-1:0] ir_id
);

  localparam int PW = ptr_width(DEPTH);

  logic [WORD_WIDTH-1:0] fpc;
  logic [WORD_WIDTH-1:0] tag;
  logic                  inflight;
  logic [PW-1:0]         count;
  logic [PW:0]           credit;
  logic                  pop;
  logic                  push;
  logic                  issue;

  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready;
  assign push     = inflight && !jump;

  // Entries held plus the word still returning, after this cycle's pop, must leave room.
  assign credit = {1'b0, count} + (PW+1)'(inflight) - (PW+1)'(pop);
  assign issue  = !rst && !jump && (credit < (PW+1)'(DEPTH));

  assign ram_en_b   = issue;
  assign ram_addr_b = fpc[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= BOOT_ADDR;
      tag      <= '0;
      inflight <= 1'b0;
    end else if (jump) begin
      fpc      <= target;
      inflight <= 1'b0;
    end else if (issue) begin
      fpc      <= fpc + 1'b1;
      tag      <= fpc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .PW         (PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (jump),
    .push    (push),
    .push_pc (tag),
    .push_ir (ram_rdata_b),
    .pop     (pop),
    .count   (count),
    .head_pc (pc_id),
    .head_ir (ir_id)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scenario bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump;
  logic [31:0] target;
  logic        ram_en_b;
  logic [8:0]  ram_addr_b;
  logic [31:0] ram_rdata_b;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] pc_id;
  logic [31:0] ir_id;

  logic [31:0] mem [512];
  int tests = 0;
  int fails = 0;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .jump        (jump),
    .target      (target),
    .ram_en_b    (ram_en_b),
    .ram_addr_b  (ram_addr_b),
    .ram_rdata_b (ram_rdata_b),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .pc_id       (pc_id),
    .ir_id       (ir_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en_b) ram_rdata_b <= mem[ram_addr_b];

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; jump = 1'b0; id_ready = 1'b0; target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; jump = 1'b0; id_ready = 1'b0; target = '0;
    @(negedge clk); #1;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", id_valid); end
    tests++; if (ir_id !== 32'h0) begin fails++; $display("FAIL reset_ir got %h want 0", ir_id); end
    tests++; if (pc_id !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", pc_id); end
    tests++; if (ram_en_b !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", ram_en_b); end
    @(negedge clk);
    rst = 1'b0; id_ready = 1'b1; #1;
    tests++; if (ram_en_b !== 1'b1 || ram_addr_b !== 9'h0) begin fails++; $display("FAIL reset_first_issue got en=%b addr=%h want en=1 addr=0", ram_en_b, ram_addr_b); end
    next_cycle;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_latency1 got valid=%b want 0", id_valid); end
    next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h0 || ir_id !== 32'h100) begin fails++; $display("FAIL reset_first_valid got v=%b pc=%h ir=%h want v=1 pc=0 ir=100", id_valid, pc_id, ir_id); end
    next_cycle;
    #2 rst = 1'b1;
    #1;
    tests++; if (id_valid !== 1'b0 || ir_id !== 32'h0 || pc_id !== 32'h0 || ram_en_b !== 1'b0) begin fails++; $display("FAIL reset_async got v=%b ir=%h pc=%h en=%b want all 0", id_valid, ir_id, pc_id, ram_en_b); end
    id_ready = 1'b0;
  endtask

  task automatic test_stream;
    do_reset;
    id_ready = 1'b1;
    next_cycle;
    next_cycle;
    for (int k = 0; k < 8; k++) begin
      tests++; if (id_valid !== 1'b1 || pc_id !== 32'(k) || ir_id !== 32'h100 + 32'(k)) begin fails++; $display("FAIL stream[%0d] got v=%b pc=%h ir=%h want v=1 pc=%h ir=%h", k, id_valid, pc_id, ir_id, k, 32'h100 + 32'(k)); end
      next_cycle;
    end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset;
    for (int k = 0; k < 8; k++) begin
      tests++; if (ram_en_b !== (k < 4)) begin fails++; $display("FAIL bp_issue[%0d] got %b want %b", k, ram_en_b, k < 4); end
      next_cycle;
    end
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests++; if (id_valid !== 1'b1 || pc_id !== 32'(k)) begin fails++; $display("FAIL bp_resume[%0d] got v=%b pc=%h want v=1 pc=%h", k, id_valid, pc_id, k); end
      next_cycle;
    end
    id_ready = 1'b0;
  endtask

  task automatic test_jump;
    do_reset;
    repeat (4) next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h0) begin fails++; $display("FAIL jump_pre got v=%b pc=%h want v=1 pc=0", id_valid, pc_id); end
    jump = 1'b1; target = 32'h40; #1;
    tests++; if (ram_en_b !== 1'b0) begin fails++; $display("FAIL jump_no_issue got %b want 0", ram_en_b); end
    next_cycle;
    jump = 1'b0; #1;
    tests++; if (id_valid !== 1'b0 || ram_en_b !== 1'b1 || ram_addr_b !== 9'h40) begin fails++; $display("FAIL jump_t1 got v=%b en=%b addr=%h want v=0 en=1 addr=40", id_valid, ram_en_b, ram_addr_b); end
    next_cycle;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL jump_t2 got v=%b want 0", id_valid); end
    next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h40 || ir_id !== 32'h140) begin fails++; $display("FAIL jump_t3 got v=%b pc=%h ir=%h want v=1 pc=40 ir=140", id_valid, pc_id, ir_id); end
    id_ready = 1'b1;
    next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h41 || ir_id !== 32'h141) begin fails++; $display("FAIL jump_t4 got v=%b pc=%h ir=%h want v=1 pc=41 ir=141", id_valid, pc_id, ir_id); end
    id_ready = 1'b0;
  endtask

  task automatic test_jump_pop;
    do_reset;
    id_ready = 1'b1;
    repeat (7) next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h5) begin fails++; $display("FAIL jpop_head got v=%b pc=%h want v=1 pc=5", id_valid, pc_id); end
    jump = 1'b1; target = 32'h80;
    next_cycle;
    jump = 1'b0; #1;
    tests++; if (id_valid !== 1'b0 || ram_addr_b !== 9'h80 || ram_en_b !== 1'b1) begin fails++; $display("FAIL jpop_t1 got v=%b en=%b addr=%h want v=0 en=1 addr=80", id_valid, ram_en_b, ram_addr_b); end
    next_cycle;
    next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h80 || ir_id !== 32'h180) begin fails++; $display("FAIL jpop_t3 got v=%b pc=%h ir=%h want v=1 pc=80 ir=180", id_valid, pc_id, ir_id); end
    id_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset;
    id_ready = 1'b1;
    jump = 1'b1; target = 32'h10;
    next_cycle;
    target = 32'h20;
    next_cycle;
    jump = 1'b0; #1;
    tests++; if (ram_en_b !== 1'b1 || ram_addr_b !== 9'h20) begin fails++; $display("FAIL b2b_issue got en=%b addr=%h want en=1 addr=20", ram_en_b, ram_addr_b); end
    next_cycle;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap got v=%b want 0", id_valid); end
    next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h20 || ir_id !== 32'h120) begin fails++; $display("FAIL b2b_head got v=%b pc=%h ir=%h want v=1 pc=20 ir=120", id_valid, pc_id, ir_id); end
    id_ready = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset;
    jump = 1'b1; target = 32'h1FF;
    next_cycle;
    jump = 1'b0; id_ready = 1'b1; #1;
    tests++; if (ram_en_b !== 1'b1 || ram_addr_b !== 9'h1FF) begin fails++; $display("FAIL wrap_addr0 got en=%b addr=%h want en=1 addr=1ff", ram_en_b, ram_addr_b); end
    next_cycle;
    tests++; if (ram_addr_b !== 9'h000) begin fails++; $display("FAIL wrap_addr1 got %h want 000", ram_addr_b); end
    next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h1FF || ir_id !== 32'h2FF) begin fails++; $display("FAIL wrap_pc0 got v=%b pc=%h ir=%h want v=1 pc=1ff ir=2ff", id_valid, pc_id, ir_id); end
    next_cycle;
    tests++; if (id_valid !== 1'b1 || pc_id !== 32'h200 || ir_id !== 32'h100) begin fails++; $display("FAIL wrap_pc1 got v=%b pc=%h ir=%h want v=1 pc=200 ir=100", id_valid, pc_id, ir_id); end
    id_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h100 + 32'(i);
    test_reset;
    test_stream;
    test_backpressure;
    test_jump;
    test_jump_pop;
    test_back_to_back;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
